// File: rtl/alu_operand_issue_pkg.sv
// alu_pkg: shared ALU opcode type, default width and opcode classifiers
package alu_pkg;
  localparam int ALU_W = 32;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_INC, OP_DEC, OP_NEG, OP_PASS} alu_op_t;
  function automatic logic is_carry_producing(alu_op_t op);
    return op != OP_PASS;
  endfunction
  function automatic logic reads_carry(alu_op_t op);
    return op == OP_ADC || op == OP_SBC;
  endfunction
endpackage

// File: rtl/alu_operand_issue_if.sv
// alu_operand_issue_if: op intake, conditioned-operand output and carry writeback bundle
interface alu_operand_issue_if import alu_pkg::*; #(parameter int N = ALU_W);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
  logic         out_c_in;
  logic [2:0]   out_op;
  logic         wb_valid;
  logic         wb_carry;
  logic         carry_flag;
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready, wb_valid, wb_carry,
    input  in_ready, out_valid, out_a, out_b, out_c_in, out_op, carry_flag
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready, wb_valid, wb_carry,
    output in_ready, out_valid, out_a, out_b, out_c_in, out_op, carry_flag
  );
endinterface

// File: rtl/alu_operand_issue_cond.sv
// alu_operand_cond: maps an ALU op and raw operands onto adder a, b and carry-in
module alu_operand_cond import alu_pkg::*; #(
  parameter int N = ALU_W
) (
  input  alu_op_t      i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cf,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_b,
  output logic         o_c_in
);
  // subtracts become invert-plus-one; INC/DEC/NEG/PASS substitute constants
  always_comb begin
    o_a    = (i_op == OP_NEG) ? '0 : i_a;
    o_b    = (i_op inside {OP_SUB, OP_SBC}) ? ~i_b :
             (i_op == OP_NEG) ? ~i_a :
             (i_op == OP_DEC) ? '1 :
             (i_op inside {OP_INC, OP_PASS}) ? '0 : i_b;
    o_c_in = reads_carry(i_op) ? i_cf : (i_op inside {OP_SUB, OP_INC, OP_NEG});
  end
endmodule

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: ALU issue stage with carry tracking; define ALU_OPERAND_ISSUE_SKID_EN for a 2-entry skid buffer
module alu_operand_issue import alu_pkg::*; #(
  parameter int N            = ALU_W,
  parameter int MAX_INFLIGHT = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_operand_issue_if.slave bus
);
  localparam int PW = $clog2(MAX_INFLIGHT + 1);
  logic          r_ov, r_shown, r_cf, r_cin;
  alu_op_t       r_op;
  logic [N-1:0]  r_a, r_b;
  logic [PW-1:0] r_pending;
  logic          w_load_en, w_src_v, w_blocked, w_out_valid, w_out_fire, w_inc, w_dec;
  logic          w_c_cin, w_h_cin;
  alu_op_t       w_src_op;
  logic [N-1:0]  w_src_a, w_src_b, w_c_a, w_c_b, w_unused_ha, w_unused_hb;
`ifdef ALU_OPERAND_ISSUE_SKID_EN
  logic          r_sv;
  alu_op_t       r_s_op;
  logic [N-1:0]  r_s_a, r_s_b;
  assign bus.in_ready = !r_sv;
  assign w_src_v      = r_sv || bus.in_valid;
  assign w_src_op     = r_sv ? r_s_op : alu_op_t'(bus.in_op);
  assign w_src_a      = r_sv ? r_s_a : bus.in_a;
  assign w_src_b      = r_sv ? r_s_b : bus.in_b;
  // skid entry captures an accepted op while the output register is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sv   <= 1'b0;
      r_s_op <= OP_ADD;
      r_s_a  <= '0;
      r_s_b  <= '0;
    end else begin
      r_sv <= r_sv ? !w_load_en : (bus.in_valid && !w_load_en);
      if (!r_sv && bus.in_valid && !w_load_en) begin
        r_s_op <= alu_op_t'(bus.in_op);
        r_s_a  <= bus.in_a;
        r_s_b  <= bus.in_b;
      end
    end
  end
`else
  assign bus.in_ready = w_load_en;
  assign w_src_v      = bus.in_valid;
  assign w_src_op     = alu_op_t'(bus.in_op);
  assign w_src_a      = bus.in_a;
  assign w_src_b      = bus.in_b;
`endif
  alu_operand_cond #(.N(N)) u_load (
    .i_op(w_src_op), .i_a(w_src_a), .i_b(w_src_b), .i_cf(r_cf),
    .o_a(w_c_a), .o_b(w_c_b), .o_c_in(w_c_cin)
  );
  alu_operand_cond #(.N(N)) u_head (
    .i_op(r_op), .i_a(r_a), .i_b(r_b), .i_cf(r_cf),
    .o_a(w_unused_ha), .o_b(w_unused_hb), .o_c_in(w_h_cin)
  );
  assign w_blocked   = !r_shown && ((reads_carry(r_op) && r_pending != '0) ||
                       (is_carry_producing(r_op) && r_pending == PW'(MAX_INFLIGHT) && !bus.wb_valid));
  assign w_out_valid = r_ov && !w_blocked;
  assign w_out_fire  = w_out_valid && bus.out_ready;
  assign w_load_en   = !r_ov || w_out_fire;
  assign w_inc       = w_out_fire && is_carry_producing(r_op);
  assign w_dec       = bus.wb_valid && r_pending != '0;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_a      = r_a;
  assign bus.out_b      = r_b;
  assign bus.out_c_in   = reads_carry(r_op) ? w_h_cin : r_cin;
  assign bus.out_op     = r_op;
  assign bus.carry_flag = r_cf;
  // output register loads conditioned operands; r_shown pins a presented entry until it fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov    <= 1'b0;
      r_shown <= 1'b0;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
    end else begin
      r_shown <= w_out_valid && !bus.out_ready;
      if (w_load_en) r_ov <= w_src_v;
      if (w_load_en && w_src_v) begin
        r_op  <= w_src_op;
        r_a   <= w_c_a;
        r_b   <= w_c_b;
        r_cin <= w_c_cin;
      end
    end
  end
  // in-flight carry counter and carry flag; writebacks with nothing pending are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_cf      <= 1'b0;
    end else begin
      if (w_inc != w_dec) r_pending <= w_inc ? r_pending + 1'b1 : r_pending - 1'b1;
      if (w_dec) r_cf <= bus.wb_carry;
    end
  end
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue: directed + random scoreboard bench for alu_operand_issue
module tb_alu_operand_issue;
  import alu_pkg::*;
  localparam int N = 32;
  localparam int MAXI = 4;
  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;
  int m_pend = 0;
  logic m_cf = 1'b0;
  exp_t q[$];
  logic prev_hold = 1'b0;
  logic [2*N+2:0] prev_data = '0;
  bit done = 0;

  alu_operand_issue_if #(.N(N)) bus ();
  alu_operand_issue #(.N(N), .MAX_INFLIGHT(MAXI)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.cin = 1'b0;
    case (op)
      3'd1: begin e.b = ~b; e.cin = 1'b1; end
      3'd3: e.b = ~b;
      3'd4: begin e.b = '0; e.cin = 1'b1; end
      3'd5: e.b = '1;
      3'd6: begin e.a = '0; e.b = ~a; e.cin = 1'b1; end
      3'd7: e.b = '0;
      default: ;
    endcase
    return e;
  endfunction

  // scoreboard monitor: push on input fire, pop and compare on output fire, track pending/CF
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_pend = 0;
      m_cf = 1'b0;
      prev_hold = 1'b0;
    end else begin
      exp_t e;
      bit d;
      chk("pending", 128'(dut.r_pending), 128'(m_pend));
      chk("carry_flag", 128'(bus.carry_flag), 128'(m_cf));
      if (prev_hold) begin
        chk("hold_valid", 128'(bus.out_valid), 128'(1));
        chk("hold_data", 128'({bus.out_op, bus.out_a, bus.out_b}), 128'(prev_data));
      end
      d = bus.wb_valid && m_pend != 0;
      if (bus.out_valid && bus.out_ready) begin
        chk("queue_nonempty", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          if (e.op == 3'd2 || e.op == 3'd3) e.cin = m_cf;
          chk("sb_op", 128'(bus.out_op), 128'(e.op));
          chk("sb_a", 128'(bus.out_a), 128'(e.a));
          chk("sb_b", 128'(bus.out_b), 128'(e.b));
          chk("sb_cin", 128'(bus.out_c_in), 128'(e.cin));
          popped++;
          if (e.op != 3'd7) m_pend++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
        pushed++;
      end
      if (d) begin
        m_pend--;
        m_cf = bus.wb_carry;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = {bus.out_op, bus.out_a, bus.out_b};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 300);
    if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic c);
    bus.wb_valid = 1'b1;
    bus.wb_carry = c;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic issue_chk(input string tag, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] ea, input logic [N-1:0] eb, input logic ec, input logic [N-1:0] es);
    send(op, a, b);
    @(negedge clk);
    chk({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
    chk({tag, "_a"}, 128'(bus.out_a), 128'(ea));
    chk({tag, "_b"}, 128'(bus.out_b), 128'(eb));
    chk({tag, "_cin"}, 128'(bus.out_c_in), 128'(ec));
    chk({tag, "_sum"}, 128'(N'(bus.out_a + bus.out_b + N'(bus.out_c_in))), 128'(es));
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_carry = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_a", 128'(bus.out_a), 128'(0));
    chk("rst_out_b", 128'(bus.out_b), 128'(0));
    chk("rst_out_c_in", 128'(bus.out_c_in), 128'(0));
    chk("rst_out_op", 128'(bus.out_op), 128'(0));
    chk("rst_carry_flag", 128'(bus.carry_flag), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    issue_chk("sub", 3'd1, 32'h5, 32'h3, 32'h5, 32'hFFFF_FFFC, 1'b1, 32'h2);
    wb(1'b0);
    send(3'd0, 32'h1, 32'h2);
    send(3'd2, 32'h3, 32'h4);
    @(negedge clk);
    chk("adc_gated0", 128'(bus.out_valid), 128'(0));
    tick();
    @(negedge clk);
    chk("adc_gated1", 128'(bus.out_valid), 128'(0));
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_carry = 1'b1;
    @(negedge clk);
    chk("adc_gated_wb", 128'(bus.out_valid), 128'(0));
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("adc_valid", 128'(bus.out_valid), 128'(1));
    chk("adc_cin", 128'(bus.out_c_in), 128'(1));
    chk("adc_op", 128'(bus.out_op), 128'(2));
    tick();
    wb(1'b0);
    for (int i = 0; i < 5; i++) send(3'd0, 32'(i), 32'(i));
    @(negedge clk);
    chk("fifth_gated0", 128'(bus.out_valid), 128'(0));
    chk("pending_max", 128'(dut.r_pending), 128'(MAXI));
    tick();
    @(negedge clk);
    chk("fifth_gated1", 128'(bus.out_valid), 128'(0));
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_carry = 1'b1;
    @(negedge clk);
    chk("fifth_valid_wb", 128'(bus.out_valid), 128'(1));
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("pending_back", 128'(dut.r_pending), 128'(MAXI));
    chk("fifth_drained", 128'(q.size()), 128'(0));
    tick();
    repeat (MAXI) wb(1'b0);
    wb(1'b1);
    @(negedge clk);
    chk("stray_wb_cf", 128'(bus.carry_flag), 128'(0));
    chk("stray_wb_pend", 128'(dut.r_pending), 128'(0));
    tick();
    issue_chk("neg", 3'd6, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF);
    issue_chk("dec", 3'd5, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
    issue_chk("pass", 3'd7, 32'h7, 32'h9, 32'h7, 32'h0, 1'b0, 32'h7);
    @(negedge clk);
    chk("pass_pending", 128'(dut.r_pending), 128'(2));
    tick();
    wb(1'b0);
    wb(1'b0);
    done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom);
        done = 1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        bus.out_ready = 1'b1;
      end
      begin
        while (!done) begin
          bus.wb_valid = (m_pend != 0) && 1'($urandom_range(0, 1));
          bus.wb_carry = 1'($urandom_range(0, 1));
          tick();
        end
        bus.wb_valid = 1'b0;
      end
    join
    for (int n = 0; n < 300 && (q.size() != 0 || m_pend != 0); n++) begin
      bus.wb_valid = m_pend != 0;
      bus.wb_carry = 1'b0;
      tick();
    end
    bus.wb_valid = 1'b0;
    chk("stream_drained", 128'(q.size()), 128'(0));
    chk("stream_count", 128'(popped), 128'(pushed));
    chk("stream_pending", 128'(dut.r_pending), 128'(0));
    send(3'd0, 32'hAA, 32'h55);
    tick();
    wb(1'b1);
    send(3'd0, 32'h1, 32'h1);
    tick();
    bus.out_ready = 1'b0;
    send(3'd1, 32'h12, 32'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_out_a", 128'(bus.out_a), 128'(0));
    chk("arst_out_b", 128'(bus.out_b), 128'(0));
    chk("arst_out_c_in", 128'(bus.out_c_in), 128'(0));
    chk("arst_out_op", 128'(bus.out_op), 128'(0));
    chk("arst_carry_flag", 128'(bus.carry_flag), 128'(0));
    chk("arst_pending", 128'(dut.r_pending), 128'(0));
    chk("arst_in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    wb(1'b1);
    @(negedge clk);
    chk("post_rst_wb_cf", 128'(bus.carry_flag), 128'(0));
    chk("post_rst_wb_pend", 128'(dut.r_pending), 128'(0));
    chk("post_rst_valid", 128'(bus.out_valid), 128'(0));
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_operand_issue.md
# alu_operand_issue

Upstream issue stage for the N-bit carry-lookahead adder. Accepts ALU ops through a valid/ready handshake, registers them, and conditions operands into the adder's `a`, `b` and `c_in`. Covers subtract via invert-plus-one, add/subtract with carry via a carry-flag register, and increment/decrement/negate. Tracks carry writebacks from downstream, so ADC/SBC never issue against a stale carry flag.

## Interface
- `N`, default 32: operand width.
- `MAX_INFLIGHT`, default 4: maximum issued carry-producing ops awaiting writeback (≥1).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: upstream op valid.
- `in_ready` output 1: stage can accept.
- `in_op` input 3: opcode.
- `in_a`, `in_b` input N: raw operands.
- `out_valid` output 1: conditioned operands valid.
- `out_ready` input 1: adder stage accepts.
- `out_a`, `out_b` output N: adder operands.
- `out_c_in` output 1: adder carry-in.
- `out_op` output 3: opcode forwarded for result handling.
- `wb_valid` input 1: downstream carry writeback strobe.
- `wb_carry` input 1: carry-out of the written-back op.
- `carry_flag` output 1: current CF register.

## Operation
- Opcodes and outputs as (`out_a`, `out_b`, `out_c_in`):
  - 0 ADD: (a, b, 0).
  - 1 SUB: (a, ~b, 1).
  - 2 ADC: (a, b, CF).
  - 3 SBC: (a, ~b, CF).
  - 4 INC: (a, 0, 1).
  - 5 DEC: (a, all-ones, 0).
  - 6 NEG: (0, ~a, 1).
  - 7 PASS: (a, 0, 0).
- Carry-producing ops are 0–6; PASS is not.
- Conditioning happens when an op is loaded into the output register. The exception is `out_c_in` for ADC/SBC, which is driven from CF while the op sits at the head.
- Input fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- `pending` counter, 0..MAX_INFLIGHT:
  - +1 on output fire of a carry-producing op.
  - −1 on `wb_valid`.
  - Both events in the same cycle: unchanged.
- CF update: `CF <= wb_carry` on `wb_valid` when pending>0.
- `wb_valid` with pending==0 is a protocol violation. It is ignored: CF and `pending` are unchanged.
- Head gating, with `out_valid` deasserted while the head entry is blocked:
  - ADC/SBC at head and pending≠0: blocked.
  - Carry-producing op at head and pending==MAX_INFLIGHT, with no `wb_valid` this cycle: blocked.
- Same-cycle writeback: a head ADC waiting on pending==1 becomes valid the cycle after `wb_valid`, with `out_c_in` = the new CF.
- Once `out_valid` is high, `out_*` stay stable until output fire. Gating only deasserts `out_valid` before it is first asserted for that entry.
- Ordering is strictly in order. No op bypasses a blocked head.

## Timing
- Latency is 1 cycle: an op accepted at edge k shows `out_valid` after edge k when not gated.
- Throughput is 1 op/cycle with `out_ready` held high and no gating.
- Reset values: `out_valid`=0, `out_a`=`out_b`=0, `out_c_in`=0, `out_op`=0, `carry_flag`=0, `pending`=0, buffer empty.
- `in_ready` after reset:
  - 1 with skid enabled.
  - 1 with skid disabled, since the buffer is empty.
- Reset asserted mid-operation discards all buffered entries and clears `pending`/CF immediately. Writebacks for ops issued before reset arrive with pending==0 and are ignored.

## Configuration
- `ALU_OPERAND_ISSUE_SKID_EN`.
- Defined: 2-entry buffer (output register plus skid register). `in_ready` is registered and equals "skid empty", so there is no combinational path from `out_ready` to `in_ready`. The skid entry loads when the input fires while the output register is held.
- Undefined: single output register, with `in_ready = !out_valid_reg || out_fire` (combinational from `out_ready`). Note that `out_valid_reg` is the occupancy bit, not the gated `out_valid`.

## Structure
- Shared package `alu_pkg`:
  - opcode enum `alu_op_t` (ADD..PASS).
  - function `is_carry_producing(op)`.
  - function `reads_carry(op)`.
  - default width constant `ALU_W` = 32.
- One sub-module `alu_operand_cond`: purely combinational (op, a, b, cf) → (a', b', c_in). It is instantiated on the load path and on the head `c_in` path.

## Test plan
- SUB a=0x0000_0005, b=0x0000_0003 → `out_b`=0xFFFF_FFFC, `out_c_in`=1, `out_valid` 1 cycle after accept; adder sum 0x2.
- ADD issued, then ADC queued, `wb_valid`=1/`wb_carry`=1 three cycles later → ADC `out_valid` low until the cycle after the writeback, then `out_c_in`=1.
- MAX_INFLIGHT=4: five back-to-back ADDs with no writeback → four fire, fifth held with `out_valid`=0. One `wb_valid` → fifth fires the next cycle; `pending` returns to 4.
- `wb_valid`=1, `wb_carry`=1 with pending=0 → `carry_flag` stays 0, `pending` stays 0.
- NEG a=0x0000_0001 → (0, 0xFFFF_FFFE, 1). DEC a=0 → `out_b`=0xFFFF_FFFF, `out_c_in`=0. PASS → `pending` unchanged.
- `out_ready` toggling randomly with continuous `in_valid` (both macro settings) → no op lost or duplicated. `rst_n` pulsed mid-stream → all outputs take reset values asynchronously.
